// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared prime, sequencer states and point type for the ECC decrypter
package ecc_pkg;

    localparam int ECC_P = 65521;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DBL,
        ST_ADD,
        ST_NEG,
        ST_SUB,
        ST_FIN
    } state_e;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
    } point_t;

    // y is negated in 17 bits so that P - y never wraps before truncation
    function automatic point_t point_neg(input point_t pt, input logic [16:0] p);
        point_t res;
        res.x = pt.x;
        res.y = (pt.y == 16'd0) ? 16'd0 : 16'(p - {1'b0, pt.y});
        return res;
    endfunction

endpackage

// File: rtl/ecc_decrypt_seq_if.sv
// rtl/ecc_decrypt_seq_if.sv - request/ack bus to the shared external point adder
interface ecc_decrypt_seq_if;

    logic        pa_req;
    logic [15:0] pa_x1;
    logic [15:0] pa_y1;
    logic [15:0] pa_x2;
    logic [15:0] pa_y2;
    logic        pa_ack;
    logic [15:0] pa_x3;
    logic [15:0] pa_y3;

    modport master (
        output pa_req, pa_x1, pa_y1, pa_x2, pa_y2,
        input  pa_ack, pa_x3, pa_y3
    );

    modport slave (
        input  pa_req, pa_x1, pa_y1, pa_x2, pa_y2,
        output pa_ack, pa_x3, pa_y3
    );

endinterface

// File: rtl/ecc_msb_find.sv
// rtl/ecc_msb_find.sv - leading-one index of a scalar plus an all-zero flag
module ecc_msb_find #(
    parameter  int DW = 7,
    localparam int IW = (DW > 1) ? $clog2(DW) : 1
) (
    input  logic [DW-1:0] vec,
    output logic [IW-1:0] idx,
    output logic          zero
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < DW; i++) begin
            if (vec[i]) begin
                idx = IW'(i);
            end
        end
        zero = (vec == '0);
    end

endmodule

// File: rtl/ecc_decrypt_seq.sv
// rtl/ecc_decrypt_seq.sv - ElGamal-style ECC decrypt sequencer: M = C2 - d*C1 via an external point adder
module ecc_decrypt_seq
    import ecc_pkg::*;
#(
    parameter int P  = ECC_P,
    parameter int DW = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [15:0]              c11,
    input  logic [15:0]              c12,
    input  logic [15:0]              c21,
    input  logic [15:0]              c22,
    input  logic [DW-1:0]            d,
    output logic                     busy,
    output logic                     done,
    output logic [15:0]              M1,
    output logic [15:0]              M2,
    ecc_decrypt_seq_if.master        pa
);

    localparam int          IW  = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [16:0] P17 = 17'(P);

    state_e        state_q, state_d;
    point_t        c1_q, c1_d;
    point_t        c2_q, c2_d;
    point_t        r_q, r_d;
    point_t        m_q, m_d;
    point_t        op_a_q, op_a_d;
    point_t        op_b_q, op_b_d;
    logic [DW-1:0] d_q, d_d;
    logic [IW-1:0] bit_q, bit_d;
    logic          req_q, req_d;

    logic [IW-1:0] msb_idx;
    logic          d_zero;
    point_t        pa_res;

    ecc_msb_find #(.DW(DW)) u_msb_find (
        .vec  (d_q),
        .idx  (msb_idx),
        .zero (d_zero)
    );

    assign pa_res = {pa.pa_x3, pa.pa_y3};

    // Each adder state first spends one cycle with req low, which gives the
    // mandatory idle cycle between back-to-back transactions.
    always_comb begin
        state_d = state_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        r_d     = r_q;
        m_d     = m_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        d_d     = d_q;
        bit_d   = bit_q;
        req_d   = req_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    c1_d    = {c11, c12};
                    c2_d    = {c21, c22};
                    d_d     = d;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (d_zero) begin
                    m_d     = c2_q;
                    state_d = ST_FIN;
                end else begin
                    r_d = c1_q;
                    if (msb_idx == '0) begin
                        state_d = ST_NEG;
                    end else begin
                        bit_d   = msb_idx - IW'(1);
                        state_d = ST_DBL;
                    end
                end
            end
            ST_DBL: begin
                if (!req_q) begin
                    op_a_d = r_q;
                    op_b_d = r_q;
                    req_d  = 1'b1;
                end else if (pa.pa_ack) begin
                    req_d = 1'b0;
                    r_d   = pa_res;
                    if (d_q[bit_q]) begin
                        state_d = ST_ADD;
                    end else if (bit_q == '0) begin
                        state_d = ST_NEG;
                    end else begin
                        bit_d   = bit_q - IW'(1);
                        state_d = ST_DBL;
                    end
                end
            end
            ST_ADD: begin
                if (!req_q) begin
                    op_a_d = r_q;
                    op_b_d = c1_q;
                    req_d  = 1'b1;
                end else if (pa.pa_ack) begin
                    req_d = 1'b0;
                    r_d   = pa_res;
                    if (bit_q == '0) begin
                        state_d = ST_NEG;
                    end else begin
                        bit_d   = bit_q - IW'(1);
                        state_d = ST_DBL;
                    end
                end
            end
            ST_NEG: begin
                r_d     = point_neg(r_q, P17);
                state_d = ST_SUB;
            end
            ST_SUB: begin
                if (!req_q) begin
                    op_a_d = c2_q;
                    op_b_d = r_q;
                    req_d  = 1'b1;
                end else if (pa.pa_ack) begin
                    req_d   = 1'b0;
                    m_d     = pa_res;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            c1_q    <= '0;
            c2_q    <= '0;
            r_q     <= '0;
            m_q     <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            d_q     <= '0;
            bit_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            r_q     <= r_d;
            m_q     <= m_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            d_q     <= d_d;
            bit_q   <= bit_d;
            req_q   <= req_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign M1        = m_q.x;
    assign M2        = m_q.y;
    assign pa.pa_req = req_q;
    assign pa.pa_x1  = op_a_q.x;
    assign pa.pa_y1  = op_a_q.y;
    assign pa.pa_x2  = op_b_q.x;
    assign pa.pa_y2  = op_b_q.y;

endmodule
